// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Imported by regfile_sb and sb_popcount.
package regfile_sb_pkg;

  localparam int unsigned ZERO_REG     = 0;
  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_NUM_REGS = 32;
  localparam int          DEF_ADDR_W   = 5;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/regfile_sb_popcount.sv
// Combinational population count of the pending vector.
// Output is wide enough to hold N.
module sb_popcount
  import regfile_sb_pkg::*;
#(
  parameter int N = DEF_NUM_REGS,
  parameter int W = cnt_width(DEF_NUM_REGS)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass and
// per-register pending bits for the hazard unit.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int CNT_W = cnt_width(NUM_REGS);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]    pop;
  logic                wr_hit, clm_hit;

  assign wr_hit  = wr_en && (wr_addr != ZA);
  assign clm_hit = claim_en && (claim_addr != ZA);

  // Claim is applied after the clear so a newer producer wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_hit) pend_d[wr_addr] = 1'b0;
    if (clm_hit) pend_d[claim_addr] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
    if (reset) pend_d = '0;
  end

  sb_popcount #(
    .N (NUM_REGS),
    .W (CNT_W)
  ) u_pop (
    .vec_i (pend_d),
    .cnt_o (pop)
  );

  assign cnt_d = (ADDR_W + 1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    if (BYPASS != 0 && wr_hit && wr_addr == rd_addr1)
      rd_data1 = wr_data;
    if (rd_addr1 == ZA) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = mem_q[rd_addr2];
    if (BYPASS != 0 && wr_hit && wr_addr == rd_addr2)
      rd_data2 = wr_data;
    if (rd_addr2 == ZA) rd_data2 = '0;
  end

  // Busy drops while its data is being forwarded, unless re-claimed.
  always_comb begin
    rd_busy1 = pend_q[rd_addr1];
    if (BYPASS != 0 && wr_hit && wr_addr == rd_addr1 &&
        !(clm_hit && claim_addr == rd_addr1))
      rd_busy1 = 1'b0;
    if (rd_addr1 == ZA) rd_busy1 = 1'b0;
  end

  always_comb begin
    rd_busy2 = pend_q[rd_addr2];
    if (BYPASS != 0 && wr_hit && wr_addr == rd_addr2 &&
        !(clm_hit && claim_addr == rd_addr2))
      rd_busy2 = 1'b0;
    if (rd_addr2 == ZA) rd_busy2 = 1'b0;
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypassed and non-bypassed
// instances share stimulus; a negedge monitor checks expectations.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, claim_addr;
  logic        wr_en, claim_en;
  logic [31:0] wr_data;

  logic [31:0] d1, d2, nd1, nd2;
  logic        b1, b2, nb1, nb2;
  logic [5:0]  cnt, ncnt;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1), .rd_data2(d2),
    .rd_busy1(b1), .rd_busy2(b2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .pending_cnt(cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nd1), .rd_data2(nd2),
    .rd_busy1(nb1), .rd_busy2(nb2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .pending_cnt(ncnt)
  );

  localparam int D1 = 0, D2 = 1, B1 = 2, B2 = 3, CN = 4;
  localparam int ND1 = 5, ND2 = 6, NB1 = 7, NB2 = 8, NCN = 9;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] get(input int s);
    case (s)
      D1:      return d1;
      D2:      return d2;
      B1:      return {31'b0, b1};
      B2:      return {31'b0, b2};
      CN:      return {26'b0, cnt};
      ND1:     return nd1;
      ND2:     return nd2;
      NB1:     return {31'b0, nb1};
      NB2:     return {31'b0, nb2};
      default: return {26'b0, ncnt};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = get(e.sig);
      n_cmp++;
      if (got !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic rst,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd,
                     input logic ce, input logic [4:0] ca,
                     input logic [4:0] a1, input logic [4:0] a2);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    rd_addr1 = a1; rd_addr2 = a2;
  endtask

  task automatic ex(input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // write r5, observe bypass vs stored
    drv(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    ex(D1, 32'hDEADBEEF, "byp_r5");
    ex(ND1, 32'h0, "nobyp_r5_old");
    tick();
    // reset with write and claim active
    drv(1, 1, 5, 32'h1111, 1, 6, 5, 6);
    ex(D1, 32'h1111, "rst_cyc_byp");
    ex(ND1, 32'hDEADBEEF, "rst_cyc_stored");
    tick();
    drv(0, 0, 0, 0, 0, 0, 5, 5);
    ex(D1, 32'h0, "rst_r5_d1");
    ex(ND2, 32'h0, "rst_r5_nb");
    ex(CN, 32'd0, "rst_cnt");
    ex(B1, 32'd0, "rst_busy1");
    ex(B2, 32'd0, "rst_busy2");
    tick();
    // r0 protection
    drv(0, 1, 0, 32'h12345678, 1, 0, 0, 0);
    ex(D1, 32'h0, "r0_byp_d1");
    ex(B1, 32'd0, "r0_busy_same");
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    ex(D1, 32'h0, "r0_d1");
    ex(ND2, 32'h0, "r0_nb_d2");
    ex(B2, 32'd0, "r0_busy2");
    ex(CN, 32'd0, "r0_cnt");
    tick();
    // bypass on r7
    drv(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 0);
    ex(D1, 32'hA5A5A5A5, "byp_r7");
    ex(ND1, 32'h0, "nobyp_r7_old");
    tick();
    drv(0, 0, 0, 0, 0, 0, 7, 0);
    ex(D1, 32'hA5A5A5A5, "r7_after");
    ex(ND1, 32'hA5A5A5A5, "nobyp_r7_after");
    tick();
    // scoreboard lifecycle on r9
    drv(0, 0, 0, 0, 1, 9, 0, 9);
    ex(B2, 32'd0, "r9_claim_same");
    ex(CN, 32'd0, "r9_cnt_before");
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9);
    ex(B2, 32'd1, "r9_busy");
    ex(CN, 32'd1, "r9_cnt1");
    ex(NCN, 32'd1, "nb_r9_cnt1");
    tick();
    drv(0, 1, 9, 32'h42, 0, 0, 0, 9);
    ex(B2, 32'd0, "r9_busy_fwd");
    ex(D2, 32'h42, "r9_d2_fwd");
    ex(NB2, 32'd1, "nb_r9_busy_wr");
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9);
    ex(B2, 32'd0, "r9_busy_clr");
    ex(CN, 32'd0, "r9_cnt0");
    ex(D2, 32'h42, "r9_d2");
    tick();
    // simultaneous claim/write on r3
    drv(0, 0, 0, 0, 1, 3, 3, 0);
    tick();
    drv(0, 1, 3, 32'h33, 1, 3, 3, 0);
    ex(CN, 32'd1, "r3_cnt1");
    ex(B1, 32'd1, "r3_busy_reclaim");
    ex(NB1, 32'd1, "nb_r3_busy");
    ex(D1, 32'h33, "r3_d1_fwd");
    tick();
    drv(0, 1, 3, 32'h34, 1, 4, 3, 4);
    ex(CN, 32'd1, "r3_cnt_kept");
    ex(B1, 32'd0, "r3_busy_fwd");
    ex(B2, 32'd0, "r4_busy_same");
    tick();
    drv(0, 0, 0, 0, 0, 0, 3, 4);
    ex(B1, 32'd0, "r3_clr");
    ex(B2, 32'd1, "r4_set");
    ex(CN, 32'd1, "r34_cnt");
    ex(D1, 32'h34, "r3_d1");
    tick();
    drv(0, 1, 4, 32'h0, 0, 0, 0, 0);
    tick();
    // reset mid-flight
    drv(0, 0, 0, 0, 1, 1, 0, 0);
    ex(CN, 32'd0, "mf_cnt0");
    tick();
    drv(0, 0, 0, 0, 1, 2, 0, 0);
    ex(CN, 32'd1, "mf_cnt1");
    tick();
    drv(0, 0, 0, 0, 1, 31, 0, 0);
    ex(CN, 32'd2, "mf_cnt2");
    tick();
    drv(1, 0, 0, 0, 0, 0, 1, 31);
    ex(CN, 32'd3, "mf_cnt3");
    ex(B1, 32'd1, "mf_busy_r1");
    ex(B2, 32'd1, "mf_busy_r31");
    tick();
    drv(0, 0, 0, 0, 0, 0, 2, 31);
    ex(B1, 32'd0, "mf_rst_busy_r2");
    ex(B2, 32'd0, "mf_rst_busy_r31");
    ex(CN, 32'd0, "mf_rst_cnt");
    ex(NCN, 32'd0, "nb_mf_rst_cnt");
    tick();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the lab04 single-cycle register file, for the pipelined datapath.
- Provides:
  - two combinational read ports with write-to-read bypass;
  - one posedge write port;
  - register 0 hardwired to zero;
  - per-register pending (scoreboard) bits that track in-flight producers, so the hazard unit can stall dependent instructions.
- Sits between the ID stage (reads, claims) and the WB stage (writes).

Parameters:
- DATA_W, 32, width of each register in bits.
- NUM_REGS, 32, number of architectural registers; a power of two, at least 2.
- ADDR_W, 5, register address width; equal to log2(NUM_REGS).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address (rs).
- rd_addr2  in  ADDR_W  read port 2 address (rt).
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- rd_busy1  out  1  pending bit of rd_addr1, combinational.
- rd_busy2  out  1  pending bit of rd_addr2, combinational.
- wr_en  in  1  write strobe from WB.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  ID issues an instruction that will write claim_addr.
- claim_addr  in  ADDR_W  destination being claimed.
- pending_cnt  out  ADDR_W+1  registered count of pending registers.

Behaviour:
- **Clock and reset:** one clock, clk; reset is synchronous and active-high.
  - On a reset cycle, all registers clear to 0, all pending bits clear, and pending_cnt becomes 0 at the next edge.
  - Reset overrides wr_en and claim_en in the same cycle.
  - Reset mid-operation discards all in-flight claims.
- **Storage:**
  - NUM_REGS x DATA_W array.
  - Entry 0 is never written and always reads 0.
  - No initial blocks are relied on; reset defines the state.
- **Write:**
  - At the rising edge, if wr_en=1 and wr_addr≠0, then mem[wr_addr] <= wr_data.
  - This replaces the previous negedge write; the half-cycle write-before-read ordering is now provided by the bypass.
- **Read, port n:**
  - rd_addrN=0 → 0.
  - Otherwise, with BYPASS=1, wr_en=1 and wr_addr=rd_addrN → wr_data.
  - Otherwise → mem[rd_addrN].
  - Zero cycles of latency; purely a function of the current inputs and state.
- **Scoreboard:** one pending bit per register; bit 0 is constant 0.
  - At the edge, with addresses ≠0:
    - claim_en sets pend[claim_addr];
    - wr_en clears pend[wr_addr].
  - If claim and write hit the same address in the same cycle, the claim wins and the bit ends at 1, because a newer producer is now in flight.
  - If they hit different addresses, both take effect.
  - A claim of an already-pending register keeps it at 1 (single-bit tracking; the pipeline guarantees in-order WB).
  - A write to a non-pending register is legal: data is stored and the bit stays 0.
- **Busy outputs:**
  - rd_busyN = pend[rd_addrN].
  - With BYPASS=1, the bit is forced to 0 when wr_en=1 and wr_addr=rd_addrN and that register is not simultaneously claimed, because the data is being forwarded this cycle.
  - Address 0 is never busy.
- **pending_cnt:**
  - Registered population count of pend, updated at every edge from the next-state pend vector.
  - Saturation is impossible; the maximum is NUM_REGS-1.
- **Widths:** addresses are compared at the full ADDR_W; there is no truncation or wrap.

Decomposition:
- The shared package holds:
  - the zero-register index constant (0);
  - defaults for DATA_W, NUM_REGS and ADDR_W;
  - a function computing the popcount width.
- One sub-module is natural: sb_popcount, which is combinational, takes a NUM_REGS-bit vector and returns ADDR_W+1 bits, and is used for pending_cnt.
- Storage, bypass and pend update stay in regfile_sb.

Test Plan:
- **Reset:** write 0xDEADBEEF to r5; assert reset for 1 cycle → rd_data1 of r5 = 0, pending_cnt = 0, both busy outputs = 0.
- **r0 protection:** wr_en with wr_addr=0, data 0x12345678; claim_en with claim_addr=0 → rd_data of r0 = 0, rd_busy = 0, pending_cnt unchanged.
- **Bypass:** rd_addr1=7 while wr_en, wr_addr=7, wr_data=0xA5A5A5A5.
  - BYPASS=1 → rd_data1 = 0xA5A5A5A5 in the same cycle.
  - BYPASS=0 → old value, then 0xA5A5A5A5 after the edge.
- **Scoreboard lifecycle:** claim r9 → next cycle rd_busy2 (rd_addr2=9) = 1 and pending_cnt = 1. Write r9 = 0x42 → bit clears and pending_cnt = 0; rd_data2 = 0x42.
- **Simultaneous claim and write:**
  - claim r3 pending; then the same cycle has wr r3 and claim r3 → pend[3] = 1 and pending_cnt unchanged.
  - Same cycle with wr r3 and claim r4 → pend[3] = 0, pend[4] = 1.
- **Reset mid-flight:** claim r1, r2 and r31 over 3 cycles (pending_cnt = 3), then reset → all busy = 0 and pending_cnt = 0 after the edge.
